// File: rtl/vending_pkg.sv
// Shared definitions for the vending front end and the vending FSM:
// channel state encoding, default debounce/jam timing and coin values.
package vending_pkg;

    typedef enum logic [1:0] {
        IDLE            = 2'd0,
        CONFIRM_PRESS   = 2'd1,
        HELD            = 2'd2,
        CONFIRM_RELEASE = 2'd3
    } chan_state_t;

    // Consecutive stable synchronised samples needed to accept an edge (>= 2).
    localparam int DEFAULT_DEBOUNCE_CYCLES = 4;
    // Cycles a switch may stay held before it is treated as jammed.
    localparam int DEFAULT_JAM_CYCLES      = 64;

    // Coin values in cents, shared with the vending FSM.
    localparam int NICKEL = 5;
    localparam int DIME   = 10;

endpackage

// File: rtl/coin_debounce.sv
// One coin channel: two-flop synchroniser, press/release debounce FSM,
// held-time counter with jam detection. press_evt is a registered
// one-cycle strobe per accepted press; release never produces an event.
module coin_debounce
    import vending_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
    parameter int JAM_CYCLES      = DEFAULT_JAM_CYCLES
) (
    input  logic clk,
    input  logic reset,
    input  logic raw,
    output logic press_evt,
    output logic jam_flag
);

    localparam int            CW       = $clog2(JAM_CYCLES + 1);
    localparam logic [CW-1:0] DEB_LAST = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [CW-1:0] JAM_MAX  = CW'(JAM_CYCLES);
    localparam logic [CW-1:0] ONE      = CW'(1);

    logic          s1;
    logic          s;
    chan_state_t   state;
    chan_state_t   state_nx;
    // cnt serves the press confirmation and the held time; rcnt counts the
    // release confirmation so a release bounce does not lose the held time.
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_nx;
    logic [CW-1:0] rcnt;
    logic [CW-1:0] rcnt_nx;
    logic          jam_nx;
    logic          evt_nx;

    // Two-flop synchroniser for the asynchronous switch input.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s1 <= 1'b0;
            s  <= 1'b0;
        end else begin
            // NOTE: non-blocking so the second flop takes the first flop's
            // pre-edge value; blocking here would collapse the two stages.
            s1 <= raw;
            s  <= s1;
        end
    end

    // Channel state, counters, jam flag and the registered press strobe.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            cnt       <= '0;
            rcnt      <= '0;
            jam_flag  <= 1'b0;
            press_evt <= 1'b0;
        end else begin
            state     <= state_nx;
            cnt       <= cnt_nx;
            rcnt      <= rcnt_nx;
            jam_flag  <= jam_nx;
            press_evt <= evt_nx;
        end
    end

    // Next-state logic for the debounce FSM.
    always_comb begin
        // NOTE: every target gets a default first, so no branch that skips
        // an assignment can infer a latch.
        state_nx = state;
        cnt_nx   = cnt;
        rcnt_nx  = rcnt;
        jam_nx   = jam_flag;
        evt_nx   = 1'b0;
        case (state)
            IDLE: begin
                if (s) begin
                    state_nx = CONFIRM_PRESS;
                    cnt_nx   = ONE;
                end
            end
            CONFIRM_PRESS: begin
                if (!s) begin
                    state_nx = IDLE;
                    cnt_nx   = '0;
                end else if (cnt == DEB_LAST) begin
                    state_nx = HELD;
                    evt_nx   = 1'b1;
                    cnt_nx   = '0;
                end else begin
                    cnt_nx = cnt + ONE;
                end
            end
            HELD: begin
                if (!s) begin
                    state_nx = CONFIRM_RELEASE;
                    rcnt_nx  = ONE;
                end else if (cnt != JAM_MAX) begin
                    cnt_nx = cnt + ONE;
                    if (cnt == JAM_MAX - ONE) jam_nx = 1'b1;
                end
            end
            CONFIRM_RELEASE: begin
                if (s) begin
                    // Release bounce: resume holding with held time and jam kept.
                    state_nx = HELD;
                    rcnt_nx  = '0;
                end else if (rcnt == DEB_LAST) begin
                    state_nx = IDLE;
                    jam_nx   = 1'b0;
                    cnt_nx   = '0;
                    rcnt_nx  = '0;
                end else begin
                    rcnt_nx = rcnt + ONE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

endmodule

// File: rtl/coin_pulse_conditioner.sv
// Coin front end: debounces both switches and serialises accepted presses
// into mutually exclusive one-cycle Nickel/Dime pulses. A coin that loses
// arbitration is held in a one-deep pending flag and emitted next cycle.
module coin_pulse_conditioner
    import vending_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
    parameter int JAM_CYCLES      = DEFAULT_JAM_CYCLES
) (
    input  logic clk,
    input  logic reset,
    input  logic nickel_raw,
    input  logic dime_raw,
    output logic Nickel,
    output logic Dime,
    output logic jam
);

    logic nickel_evt;
    logic dime_evt;
    logic nickel_jam;
    logic dime_jam;
    logic pend_n;
    logic pend_d;
    logic pend_n_nx;
    logic pend_d_nx;
    logic nickel_nx;
    logic dime_nx;

    coin_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
        .JAM_CYCLES     (JAM_CYCLES)
    ) u_nickel (
        .clk      (clk),
        .reset    (reset),
        .raw      (nickel_raw),
        .press_evt(nickel_evt),
        .jam_flag (nickel_jam)
    );

    coin_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
        .JAM_CYCLES     (JAM_CYCLES)
    ) u_dime (
        .clk      (clk),
        .reset    (reset),
        .raw      (dime_raw),
        .press_evt(dime_evt),
        .jam_flag (dime_jam)
    );

    // Arbiter: older pending coins first, nickel before dime on a tie.
    always_comb begin
        nickel_nx = 1'b0;
        dime_nx   = 1'b0;
        pend_n_nx = pend_n | nickel_evt;
        pend_d_nx = pend_d | dime_evt;
        if (pend_n) begin
            nickel_nx = 1'b1;
            pend_n_nx = nickel_evt;
        end else if (pend_d) begin
            dime_nx   = 1'b1;
            pend_d_nx = dime_evt;
        end else if (nickel_evt) begin
            nickel_nx = 1'b1;
            pend_n_nx = 1'b0;
        end else if (dime_evt) begin
            dime_nx   = 1'b1;
            pend_d_nx = 1'b0;
        end
    end

    // Output pulses, pending flags and the combined jam level.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            Nickel <= 1'b0;
            Dime   <= 1'b0;
            pend_n <= 1'b0;
            pend_d <= 1'b0;
            jam    <= 1'b0;
        end else begin
            Nickel <= nickel_nx;
            Dime   <= dime_nx;
            pend_n <= pend_n_nx;
            pend_d <= pend_d_nx;
            jam    <= nickel_jam | dime_jam;
        end
    end

endmodule

// File: tb/tb_coin_pulse_conditioner.sv
// Bench for coin_pulse_conditioner. The reference model treats each channel
// as a debounced level that flips after DEB consecutive opposite samples,
// tracks held time for jam, and queues accepted coins one per cycle.
module tb_coin_pulse_conditioner;

    localparam int DEB = 4;
    localparam int JAM = 64;

    logic clk = 1'b0;
    logic reset;
    logic nickel_raw;
    logic dime_raw;
    logic Nickel;
    logic Dime;
    logic jam;

    int checks = 0;
    int errors = 0;

    coin_pulse_conditioner #(
        .DEBOUNCE_CYCLES(DEB),
        .JAM_CYCLES     (JAM)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .nickel_raw(nickel_raw),
        .dime_raw  (dime_raw),
        .Nickel    (Nickel),
        .Dime      (Dime),
        .jam       (jam)
    );

    always #5 clk = ~clk;

    // Reference model state (index 0 = nickel, 1 = dime).
    logic sd1 [2];
    logic sd2 [2];
    logic lvl [2];
    int   run [2];
    int   held[2];
    logic jamf[2];
    logic evt [2];
    int   coin_q[$];
    logic exp_nickel;
    logic exp_dime;
    logic exp_jam;

    task automatic model_reset();
        for (int c = 0; c < 2; c++) begin
            sd1[c] = 1'b0; sd2[c] = 1'b0; lvl[c] = 1'b0;
            run[c] = 0; held[c] = 0; jamf[c] = 1'b0; evt[c] = 1'b0;
        end
        coin_q.delete();
        exp_nickel = 1'b0;
        exp_dime   = 1'b0;
        exp_jam    = 1'b0;
    endtask

    // Advance the model by one rising edge given the raw inputs at that edge.
    task automatic model_tick(input logic n, input logic d);
        logic raw[2];
        logic smp;
        int   coin;
        raw[0] = n;
        raw[1] = d;
        // Outputs registered at this edge come from the events of the last one.
        if (evt[0]) coin_q.push_back(0);
        if (evt[1]) coin_q.push_back(1);
        exp_nickel = 1'b0;
        exp_dime   = 1'b0;
        if (coin_q.size() > 0) begin
            coin = coin_q.pop_front();
            if (coin == 0) exp_nickel = 1'b1;
            else           exp_dime   = 1'b1;
        end
        exp_jam = jamf[0] | jamf[1];
        for (int c = 0; c < 2; c++) begin
            smp    = sd2[c];
            sd2[c] = sd1[c];
            sd1[c] = raw[c];
            evt[c] = 1'b0;
            if (smp != lvl[c]) begin
                run[c]++;
                if (run[c] == DEB) begin
                    lvl[c]  = smp;
                    run[c]  = 0;
                    held[c] = 0;
                    if (smp) evt[c]  = 1'b1;
                    else     jamf[c] = 1'b0;
                end
            end else begin
                if (lvl[c] && run[c] == 0) begin
                    if (held[c] < JAM) held[c]++;
                    if (held[c] == JAM) jamf[c] = 1'b1;
                end
                run[c] = 0;
            end
        end
    endtask

    task automatic step(input logic n, input logic d);
        @(negedge clk);
        nickel_raw = n;
        dime_raw   = d;
        @(posedge clk);
        model_tick(n, d);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        nickel_raw = 1'b0;
        dime_raw   = 1'b0;
        model_reset();
        #3;
        checks++;
        if (Nickel !== 1'b0 || Dime !== 1'b0 || jam !== 1'b0) begin
            errors++;
            $display("FAIL reset_state got N%b D%b J%b expected N0 D0 J0", Nickel, Dime, jam);
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        for (int k = 0; k < 6; k++) begin
            step(1'b0, 1'b0);
            checks++;
            if (Nickel !== 1'b0 || Dime !== 1'b0 || jam !== 1'b0) begin
                errors++;
                $display("FAIL reset_idle cycle %0d got N%b D%b J%b expected N0 D0 J0", k, Nickel, Dime, jam);
            end
        end
    endtask

    task automatic test_clean_nickel();
        int pulses = 0;
        int first  = -1;
        for (int k = 1; k <= 20; k++) begin
            step(k <= 10, 1'b0);
            checks++;
            if (Nickel !== exp_nickel || Dime !== exp_dime || jam !== exp_jam) begin
                errors++;
                $display("FAIL clean_nickel cycle %0d got N%b D%b J%b expected N%b D%b J%b",
                         k, Nickel, Dime, jam, exp_nickel, exp_dime, exp_jam);
            end
            if (Nickel === 1'b1) begin
                pulses++;
                if (first < 0) first = k;
            end
        end
        checks++;
        if (pulses != 1 || first != 7) begin
            errors++;
            $display("FAIL clean_nickel_timing got %0d pulses first at edge %0d expected 1 pulse at edge 7", pulses, first);
        end
    endtask

    task automatic test_bounce_reject();
        logic pat[4] = '{1'b1, 1'b0, 1'b1, 1'b0};
        int pulses = 0;
        for (int k = 0; k < 16; k++) begin
            step(1'b0, (k < 4) ? pat[k] : 1'b0);
            checks++;
            if (Nickel !== exp_nickel || Dime !== exp_dime || jam !== exp_jam) begin
                errors++;
                $display("FAIL bounce_reject cycle %0d got N%b D%b J%b expected N%b D%b J%b",
                         k, Nickel, Dime, jam, exp_nickel, exp_dime, exp_jam);
            end
            if (Dime === 1'b1) pulses++;
        end
        checks++;
        if (pulses != 0) begin
            errors++;
            $display("FAIL bounce_reject_count got %0d dime pulses expected 0", pulses);
        end
    endtask

    task automatic test_bouncy_accept();
        // bounce, stable high, bounce on release, then quiet
        logic pat[14] = '{1'b1, 1'b0, 1'b1,
                          1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1,
                          1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        int pulses = 0;
        for (int k = 0; k < 30; k++) begin
            step(1'b0, (k < 14) ? pat[k] : 1'b0);
            checks++;
            if (Nickel !== exp_nickel || Dime !== exp_dime || jam !== exp_jam) begin
                errors++;
                $display("FAIL bouncy_accept cycle %0d got N%b D%b J%b expected N%b D%b J%b",
                         k, Nickel, Dime, jam, exp_nickel, exp_dime, exp_jam);
            end
            if (Dime === 1'b1) pulses++;
        end
        checks++;
        if (pulses != 1) begin
            errors++;
            $display("FAIL bouncy_accept_count got %0d dime pulses expected 1", pulses);
        end
    endtask

    task automatic test_simultaneous();
        int n_at = -1;
        int d_at = -1;
        int both = 0;
        for (int k = 1; k <= 24; k++) begin
            step(k <= 10, k <= 10);
            checks++;
            if (Nickel !== exp_nickel || Dime !== exp_dime || jam !== exp_jam) begin
                errors++;
                $display("FAIL simultaneous cycle %0d got N%b D%b J%b expected N%b D%b J%b",
                         k, Nickel, Dime, jam, exp_nickel, exp_dime, exp_jam);
            end
            if (Nickel === 1'b1 && n_at < 0) n_at = k;
            if (Dime === 1'b1 && d_at < 0) d_at = k;
            if (Nickel === 1'b1 && Dime === 1'b1) both++;
        end
        checks++;
        if (n_at != 7 || d_at != 8 || both != 0) begin
            errors++;
            $display("FAIL simultaneous_order got nickel@%0d dime@%0d overlap %0d expected nickel@7 dime@8 overlap 0",
                     n_at, d_at, both);
        end
    endtask

    task automatic test_jam();
        int pulses = 0;
        int rise   = -1;
        int fall   = -1;
        for (int k = 1; k <= 96; k++) begin
            step(k <= 80, 1'b0);
            checks++;
            if (Nickel !== exp_nickel || Dime !== exp_dime || jam !== exp_jam) begin
                errors++;
                $display("FAIL jam cycle %0d got N%b D%b J%b expected N%b D%b J%b",
                         k, Nickel, Dime, jam, exp_nickel, exp_dime, exp_jam);
            end
            if (Nickel === 1'b1) pulses++;
            if (jam === 1'b1 && rise < 0) rise = k;
            if (jam === 1'b0 && rise >= 0 && fall < 0) fall = k;
        end
        checks++;
        if (pulses != 1 || rise != 71 || fall != 87) begin
            errors++;
            $display("FAIL jam_timing got %0d pulses jam rise %0d fall %0d expected 1 pulse rise 71 fall 87",
                     pulses, rise, fall);
        end
    endtask

    task automatic test_reset_mid();
        int pulses = 0;
        int guard  = 0;
        // Dime confirming when reset hits.
        for (int k = 1; k <= 5; k++) step(1'b0, 1'b1);
        #2 reset = 1'b0;
        #1;
        model_reset();
        checks++;
        if (Nickel !== 1'b0 || Dime !== 1'b0 || jam !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_outputs got N%b D%b J%b expected N0 D0 J0", Nickel, Dime, jam);
        end
        @(negedge clk);
        dime_raw = 1'b0;
        reset    = 1'b1;
        for (int k = 0; k < 20; k++) begin
            step(1'b0, 1'b0);
            checks++;
            if (Nickel !== exp_nickel || Dime !== exp_dime || jam !== exp_jam) begin
                errors++;
                $display("FAIL reset_mid cycle %0d got N%b D%b J%b expected N%b D%b J%b",
                         k, Nickel, Dime, jam, exp_nickel, exp_dime, exp_jam);
            end
            if (Dime === 1'b1) pulses++;
        end
        checks++;
        if (pulses != 0) begin
            errors++;
            $display("FAIL reset_mid_count got %0d dime pulses expected 0", pulses);
        end
        // Reset while a dime is pending behind a nickel.
        while (Nickel !== 1'b1 && guard < 20) begin
            step(1'b1, 1'b1);
            guard++;
        end
        checks++;
        if (Nickel !== 1'b1) begin
            errors++;
            $display("FAIL reset_pending_wait got no nickel within %0d cycles expected a nickel", guard);
        end
        #2 reset = 1'b0;
        #1;
        model_reset();
        @(negedge clk);
        nickel_raw = 1'b0;
        dime_raw   = 1'b0;
        reset      = 1'b1;
        pulses     = 0;
        for (int k = 0; k < 15; k++) begin
            step(1'b0, 1'b0);
            checks++;
            if (Nickel !== exp_nickel || Dime !== exp_dime || jam !== exp_jam) begin
                errors++;
                $display("FAIL reset_pending cycle %0d got N%b D%b J%b expected N%b D%b J%b",
                         k, Nickel, Dime, jam, exp_nickel, exp_dime, exp_jam);
            end
            if (Nickel === 1'b1 || Dime === 1'b1) pulses++;
        end
        checks++;
        if (pulses != 0) begin
            errors++;
            $display("FAIL reset_pending_count got %0d pulses expected 0", pulses);
        end
    endtask

    task automatic test_random();
        logic tgt_n = 1'b0;
        logic tgt_d = 1'b0;
        logic n;
        logic d;
        int   coins = 0;
        for (int k = 0; k < 900; k++) begin
            if ($urandom_range(0, 15) == 0) tgt_n = ~tgt_n;
            if ($urandom_range(0, 15) == 0) tgt_d = ~tgt_d;
            n = tgt_n ^ ($urandom_range(0, 9) == 0);
            d = tgt_d ^ ($urandom_range(0, 9) == 0);
            if (k >= 880) begin
                n = 1'b0;
                d = 1'b0;
            end
            step(n, d);
            checks++;
            if (Nickel !== exp_nickel || Dime !== exp_dime || jam !== exp_jam) begin
                errors++;
                $display("FAIL random cycle %0d got N%b D%b J%b expected N%b D%b J%b",
                         k, Nickel, Dime, jam, exp_nickel, exp_dime, exp_jam);
            end
            if (Nickel === 1'b1 || Dime === 1'b1) coins++;
        end
        $display("random run emitted %0d coins", coins);
    endtask

    initial begin
        test_reset();
        test_clean_nickel();
        test_bounce_reject();
        test_bouncy_accept();
        test_simultaneous();
        test_jam();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

endmodule
